// File: rtl/scalar_recoder.sv
// Recodes a 256-bit Ed25519 scalar into 64 signed radix-16 digits and streams them to the
// fixed-base select stage. Define SCALAR_CLAMP_EN to apply RFC 8032 clamping on load.
module scalar_recoder #(
   parameter int unsigned ODD_FIRST = 1,
   parameter int unsigned DIG_W     = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [255:0]     scalar,
   output logic             busy,
   output logic             dig_valid,
   input  logic             dig_ready,
   output logic [4:0]       dig_pos,
   output logic [DIG_W-1:0] dig_b,
   output logic             dig_phase,
   output logic             dig_last,
   output logic             done,
   output logic             range_err
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] RECODE = 2'd1;
   localparam logic [1:0] EMIT   = 2'd2;
   localparam logic [1:0] FIN    = 2'd3;

   logic [1:0]   state_q, state_d;
   logic [255:0] nib_q;
   logic         carry_q;
   logic [5:0]   cnt_q;
   logic [5:0]   buf_q [64];
   logic [255:0] load;
   logic [5:0]   t;
   logic         c;
   logic [5:0]   e_rec;
   logic [5:0]   idx;
   logic [5:0]   sel;

`ifdef SCALAR_CLAMP_EN
   assign load      = {2'b01, scalar[253:3], 3'b000};
   assign range_err = 1'b0;
`else
   logic range_err_q;
   assign load      = scalar;
   assign range_err = range_err_q;
`endif

   // t is 0..16, so (t+8)>>4 reduces to a single compare.
   assign t     = {2'b00, nib_q[3:0]} + {5'b00000, carry_q};
   assign c     = (t >= 6'd8);
   assign e_rec = (cnt_q == 6'd63) ? t : t - {1'b0, c, 4'b0000};

   always_comb begin
      if (ODD_FIRST != 0) begin
         idx       = {cnt_q[4:0], ~cnt_q[5]};
         dig_phase = cnt_q[5];
         dig_last  = dig_valid & (&cnt_q[4:0]);
      end else begin
         idx       = cnt_q;
         dig_phase = 1'b0;
         dig_last  = dig_valid & (&cnt_q);
      end
   end

   assign sel       = buf_q[idx];
   assign dig_pos   = idx[5:1];
   assign dig_b     = {{(DIG_W-6){sel[5]}}, sel};
   assign dig_valid = (state_q == EMIT);
   assign busy      = (state_q == RECODE) || (state_q == EMIT);
   assign done      = (state_q == FIN);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RECODE;
         RECODE:  if (cnt_q == 6'd63) state_d = EMIT;
         EMIT:    if (dig_ready && cnt_q == 6'd63) state_d = FIN;
         default: state_d = IDLE;
      endcase
   end

   // cnt_q indexes nibbles during RECODE and transfers during EMIT; it wraps to 0 between.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         nib_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         for (int i = 0; i < 64; i++) buf_q[i] <= '0;
`ifndef SCALAR_CLAMP_EN
         range_err_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (start) begin
                  nib_q   <= load;
                  carry_q <= 1'b0;
                  cnt_q   <= '0;
`ifndef SCALAR_CLAMP_EN
                  range_err_q <= 1'b0;
`endif
               end
            end
            RECODE: begin
               buf_q[cnt_q] <= e_rec;
               nib_q        <= nib_q >> 4;
               carry_q      <= c;
               cnt_q        <= cnt_q + 6'd1;
`ifndef SCALAR_CLAMP_EN
               if (cnt_q == 6'd63) range_err_q <= (t > 6'd8);
`endif
            end
            EMIT: begin
               if (dig_ready) cnt_q <= cnt_q + 6'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_scalar_recoder.sv
// Scoreboard bench for scalar_recoder: expected digits are queued at stimulus time and
// popped by monitors on each handshake. Honours SCALAR_CLAMP_EN in its expectations.
module tb_scalar_recoder;

   typedef struct packed {
      logic [4:0] pos;
      logic [7:0] b;
      logic       phase;
      logic       last;
   } dig_t;

   logic         clk = 1'b0;
   logic         rst_n, start, dig_ready;
   logic [255:0] scalar;
   logic         busy, dig_valid, dig_phase, dig_last, done, range_err;
   logic [4:0]   dig_pos;
   logic [7:0]   dig_b;

   logic         n_start, n_ready;
   logic [255:0] n_scalar;
   logic         n_busy, n_valid, n_phase, n_last, n_done, n_rerr;
   logic [4:0]   n_pos;
   logic [7:0]   n_b;

   dig_t              exp_q[$];
   dig_t              nexp_q[$];
   logic signed [7:0] exp_e [64];
   int                n_cmp = 0;
   int                n_bad = 0;
   int                xfers = 0;
   int                nxfers = 0;
   int                cyc;
   dig_t              cur, held, ncur, want;
   logic              held_v = 1'b0;

   always #5 clk = ~clk;

   scalar_recoder #(.ODD_FIRST(1), .DIG_W(8)) u_odd (
      .clk(clk), .rst_n(rst_n), .start(start), .scalar(scalar), .busy(busy),
      .dig_valid(dig_valid), .dig_ready(dig_ready), .dig_pos(dig_pos), .dig_b(dig_b),
      .dig_phase(dig_phase), .dig_last(dig_last), .done(done), .range_err(range_err)
   );

   scalar_recoder #(.ODD_FIRST(0), .DIG_W(8)) u_nat (
      .clk(clk), .rst_n(rst_n), .start(n_start), .scalar(n_scalar), .busy(n_busy),
      .dig_valid(n_valid), .dig_ready(n_ready), .dig_pos(n_pos), .dig_b(n_b),
      .dig_phase(n_phase), .dig_last(n_last), .done(n_done), .range_err(n_rerr)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, act, req);
      end
   endtask

   // Odd-first monitor: checks each transfer and that stalled outputs stay put.
   always @(negedge clk) begin
      cur = {dig_pos, dig_b, dig_phase, dig_last};
      if (rst_n && dig_valid) begin
         if (held_v) check("stall_hold", 64'(cur), 64'(held));
         if (dig_ready) begin
            if (exp_q.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL extra_digit: got %h want none", cur);
            end else begin
               want = exp_q.pop_front();
               check($sformatf("odd_digit[%0d]", xfers), 64'(cur), 64'(want));
            end
            xfers++;
         end
         held_v = !dig_ready;
         held   = cur;
      end else begin
         held_v = 1'b0;
      end
   end

   always @(negedge clk) begin
      ncur = {n_pos, n_b, n_phase, n_last};
      if (rst_n && n_valid && n_ready) begin
         if (nexp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL extra_nat_digit: got %h want none", ncur);
         end else begin
            want = nexp_q.pop_front();
            check($sformatf("nat_digit[%0d]", nxfers), 64'(ncur), 64'(want));
         end
         nxfers++;
      end
   end

   task automatic clear_exp();
      for (int i = 0; i < 64; i++) exp_e[i] = 8'sd0;
`ifdef SCALAR_CLAMP_EN
      exp_e[63] = 8'sd4;  // clamped bit 254 lands in the top nibble
`endif
   endtask

   task automatic push_odd();
      int ix;
      for (int k = 0; k < 64; k++) begin
         ix = (k < 32) ? 2 * k + 1 : 2 * (k - 32);
         exp_q.push_back({5'(ix / 2), exp_e[ix], (k >= 32), (k == 31 || k == 63)});
      end
   endtask

   task automatic push_nat();
      for (int k = 0; k < 64; k++) nexp_q.push_back({5'(k / 2), exp_e[k], 1'b0, (k == 63)});
   endtask

   task automatic start_odd(input logic [255:0] s);
      xfers = 0;
      @(posedge clk); #1;
      scalar = s; start = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
      cyc = 1;
      while (!dig_valid && cyc < 200) begin
         @(posedge clk); #2;
         cyc++;
      end
   endtask

   task automatic wait_done(input bit bp);
      int n;
      n = 0;
      while (xfers < 64 && n < 1000) begin
         @(posedge clk); #2;
         if (bp) dig_ready = ~dig_ready;
         n++;
      end
      check("xfer_count", 64'(xfers), 64'd64);
      check("queue_drained", 64'(exp_q.size()), 64'd0);
      check("done_busy", {62'd0, done, busy}, 64'b10);
      dig_ready = 1'b1;
      @(posedge clk); #2;
      check("done_pulse_end", 64'(done), 64'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0; start = 1'b0; dig_ready = 1'b1; scalar = '0;
      n_start = 1'b0; n_ready = 1'b1; n_scalar = '0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      check("reset_ctrl", {58'd0, busy, dig_valid, dig_last, done, range_err, dig_phase}, 64'd0);
      check("reset_data", {51'd0, dig_pos, dig_b}, 64'd0);

      // Zero scalar: latency, ordering, dig_last positions.
      clear_exp(); push_odd();
      start_odd(256'd0);
      check("first_valid_cycle", 64'(cyc), 64'd65);
      check("rerr_zero", 64'(range_err), 64'd0);
      wait_done(1'b0);

      // 0x88 -> e0=-8, e1=-7, e2=1.
      clear_exp();
      exp_e[0] = -8'sd8; exp_e[1] = -8'sd7; exp_e[2] = 8'sd1;
      push_odd();
      start_odd(256'h88);
      wait_done(1'b0);

      // Natural order on the second instance.
      clear_exp();
`ifdef SCALAR_CLAMP_EN
      exp_e[0] = -8'sd8; exp_e[1] = 8'sd1;
`else
      exp_e[0] = -8'sd1; exp_e[1] = 8'sd1;
`endif
      push_nat();
      nxfers = 0;
      @(posedge clk); #1;
      n_scalar = 256'h0F; n_start = 1'b1;
      @(posedge clk); #2;
      n_start = 1'b0;
      cyc = 0;
      while (!n_done && cyc < 300) begin
         @(posedge clk); #2;
         cyc++;
      end
      check("nat_done", 64'(n_done), 64'd1);
      check("nat_count", 64'(nxfers), 64'd64);

      // Backpressure with scalar=1.
      clear_exp();
`ifndef SCALAR_CLAMP_EN
      exp_e[0] = 8'sd1;
`endif
      push_odd();
      start_odd(256'd1);
      wait_done(1'b1);

      // All ones: top digit overflows unless clamped.
      clear_exp();
`ifdef SCALAR_CLAMP_EN
      exp_e[0] = -8'sd8; exp_e[63] = 8'sd8;
`else
      exp_e[0] = -8'sd1; exp_e[63] = 8'sd16;
`endif
      push_odd();
      start_odd({256{1'b1}});
`ifdef SCALAR_CLAMP_EN
      check("rerr_ones", 64'(range_err), 64'd0);
`else
      check("rerr_ones", 64'(range_err), 64'd1);
`endif
      wait_done(1'b0);
`ifndef SCALAR_CLAMP_EN
      check("rerr_sticky", 64'(range_err), 64'd1);
`endif

      clear_exp(); push_odd();
      start_odd(256'd0);
      check("rerr_cleared", 64'(range_err), 64'd0);
      wait_done(1'b0);

      // Reset after the 10th transfer aborts the stream.
      clear_exp();
      exp_e[0] = -8'sd8; exp_e[1] = -8'sd7; exp_e[2] = 8'sd1;
      push_odd();
      start_odd(256'h88);
      cyc = 0;
      while (xfers < 10 && cyc < 200) begin
         @(posedge clk); #2;
         cyc++;
      end
      rst_n = 1'b0;
      @(posedge clk); #2;
      rst_n = 1'b1;
      check("abort_xfers", 64'(xfers), 64'd10);
      check("abort_ctrl", {61'd0, dig_valid, busy, done}, 64'd0);
      check("abort_data", {51'd0, dig_pos, dig_b}, 64'd0);
      exp_q.delete();

      clear_exp();
`ifndef SCALAR_CLAMP_EN
      exp_e[0] = 8'sd1;
`endif
      push_odd();
      start_odd(256'd1);
      check("restart_latency", 64'(cyc), 64'd65);
      wait_done(1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
